// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline control slice: forwarding select
// codes, hazard-sequencer state encodings and the forwarding decision helper.
package pipe_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MEMW  = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  // Chooses the ALU operand source for one EX source register. The younger
  // result sitting in EX_MEM takes priority over the older one in MEM_WB,
  // and $zero is never forwarded because it is hard-wired to zero.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic       mem_rw,
    input logic [4:0] mem_wreg,
    input logic       wb_rw,
    input logic [4:0] wb_wreg
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_rw && (mem_wreg != REG_ZERO) && (mem_wreg == src)) begin
      sel = FWD_MEM;
    end else if (wb_rw && (wb_wreg != REG_ZERO) && (wb_wreg == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Pure combinational EX-stage forwarding unit. Kept separate so a future
// branch-resolved-in-ID path can instantiate a second copy on ID operands.
module forward_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_wreg,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_wreg,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // Both operands use the same EX_MEM-over-MEM_WB priority rule.
  always_comb begin
    fwd_a = fwd_select(ex_rs, mem_reg_write, mem_wreg, wb_reg_write, wb_wreg);
    fwd_b = fwd_select(ex_rt, mem_reg_write, mem_wreg, wb_reg_write, wb_wreg);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline. Generates per-stage write
// enables and flushes, inserts a single bubble on load-use, squashes the
// wrong path on a taken branch or jump, freezes the pipe while data memory
// is busy, and keeps stall/flush performance counters plus a memory watchdog.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_wreg,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_wreg,
  input  logic             pcsrc_mem,
  input  logic             jump_mem,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int               WDOG_W    = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic              pend_redir;
  logic [WDOG_W-1:0] wdog;
  logic              redirect_req;
  logic              redirect_go;
  logic              load_use;
  logic [1:0]        fwd_a_raw;
  logic [1:0]        fwd_b_raw;

  forward_unit u_fwd (
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_reg_write (mem_reg_write),
    .mem_wreg      (mem_wreg),
    .wb_reg_write  (wb_reg_write),
    .wb_wreg       (wb_wreg),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  // Forwarding selects are forced to the register file while in reset.
  always_comb begin
    fwd_a = reset ? FWD_RF : fwd_a_raw;
    fwd_b = reset ? FWD_RF : fwd_b_raw;
  end

  // Raw hazard conditions; a redirect that arrived while memory was busy is
  // remembered in pend_redir so it is not lost when MEM unfreezes.
  always_comb begin
    redirect_req = pcsrc_mem | jump_mem | pend_redir;
    redirect_go  = redirect_req & ~dmem_busy & ~reset;
    load_use     = ex_mem_read && (ex_wreg != REG_ZERO) &&
                   ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Mealy stage controls, priority busy > redirect > load-use.
  always_comb begin
    state_nxt    = state;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_hold    = 1'b0;
    if (!reset) begin
      if (dmem_busy) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_hold   = 1'b1;
        state_nxt   = ST_MEMW;
      end else if (redirect_go) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        state_nxt    = (state == ST_RUN) ? ST_REDIR : ST_RUN;
      end else begin
        case (state)
          ST_RUN: begin
            if (load_use) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end
            state_nxt = ST_RUN;
          end
          ST_MEMW:  state_nxt = ST_RUN;
          ST_REDIR: state_nxt = ST_RUN;
          default:  state_nxt = ST_RUN;
        endcase
      end
    end
  end

  // Pending-redirect latch: captured during a memory freeze, dropped once
  // the redirect is actually taken or on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_redir <= 1'b0;
    end else if (dmem_busy) begin
      if (pcsrc_mem || jump_mem) begin
        pend_redir <= 1'b1;
      end
    end else if (redirect_go) begin
      pend_redir <= 1'b0;
    end
  end

  // Watchdog on consecutive busy cycles; the timeout flag is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog        <= '0;
      mem_timeout <= 1'b0;
    end else if (dmem_busy) begin
      if (wdog == WDOG_LAST) begin
        mem_timeout <= 1'b1;
      end else begin
        wdog <= wdog + WDOG_W'(1);
      end
    end else begin
      wdog <= '0;
    end
  end

  // Saturating performance counters for stalled cycles and taken redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect_go && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl. Small counter width
// and a short watchdog make saturation and timeout reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int WDOG  = 4;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
  logic             id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write;
  logic             pcsrc_mem, jump_mem, dmem_busy;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic             pipe_hold, mem_timeout;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int vec_cnt;
  int err_cnt;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_wreg(ex_wreg),
    .mem_reg_write(mem_reg_write), .mem_wreg(mem_wreg),
    .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg),
    .pcsrc_mem(pcsrc_mem), .jump_mem(jump_mem), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .pipe_hold(pipe_hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0;
    ex_mem_read = 0; ex_wreg = 0; mem_reg_write = 0; mem_wreg = 0;
    wb_reg_write = 0; wb_wreg = 0; pcsrc_mem = 0; jump_mem = 0; dmem_busy = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Set the ID/EX fields for "lw $2 in EX, add $3,$2,$4 in ID".
  task automatic set_load_use();
    ex_mem_read = 1; ex_wreg = 5'd2; id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    set_load_use();
    dmem_busy = 1; mem_reg_write = 1; mem_wreg = 5'd7; ex_rs = 5'd7;
    #1;
    vec_cnt++;
    if (pc_write !== 1'b1 || if_id_write !== 1'b1 || pipe_hold !== 1'b0 ||
        id_ex_flush !== 1'b0 || fwd_a !== 2'b00) begin
      err_cnt++;
      $display("[TB] FAIL reset_comb: pc_write=%b if_id_write=%b hold=%b id_ex_flush=%b fwd_a=%b, required 1 1 0 0 00",
               pc_write, if_id_write, pipe_hold, id_ex_flush, fwd_a);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || mem_timeout !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL reset_regs: stall=%0d flush=%0d timeout=%b, required 0 0 0",
               stall_cnt, flush_cnt, mem_timeout);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    set_load_use();
    #1;
    vec_cnt++;
    if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_flush !== 1'b1 ||
        if_id_flush !== 1'b0 || pipe_hold !== 1'b0 || stall_cnt !== 0) begin
      err_cnt++;
      $display("[TB] FAIL load_use_stall: pc=%b ifid_w=%b idex_f=%b ifid_f=%b hold=%b stall=%0d, required 0 0 1 0 0 0",
               pc_write, if_id_write, id_ex_flush, if_id_flush, pipe_hold, stall_cnt);
    end
    @(negedge clk);
    ex_mem_read = 0;
    #1;
    vec_cnt++;
    if (pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_flush !== 1'b0 || stall_cnt !== 1) begin
      err_cnt++;
      $display("[TB] FAIL load_use_release: pc=%b ifid_w=%b idex_f=%b stall=%0d, required 1 1 0 1",
               pc_write, if_id_write, id_ex_flush, stall_cnt);
    end
    @(negedge clk);
    ex_mem_read = 1; ex_wreg = 5'd4; id_rs = 5'd9; id_rt = 5'd4; id_uses_rt = 1;
    #1;
    vec_cnt++;
    if (pc_write !== 1'b0 || id_ex_flush !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL load_use_rt: pc=%b idex_f=%b, required 0 1", pc_write, id_ex_flush);
    end
    @(negedge clk);
    id_uses_rt = 0;
    #1;
    vec_cnt++;
    if (pc_write !== 1'b1 || id_ex_flush !== 1'b0 || stall_cnt !== 2) begin
      err_cnt++;
      $display("[TB] FAIL load_use_rt_unused: pc=%b idex_f=%b stall=%0d, required 1 0 2",
               pc_write, id_ex_flush, stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    do_reset();
    @(negedge clk);
    ex_mem_read = 1; ex_wreg = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1;
    mem_reg_write = 1; mem_wreg = 5'd0; wb_reg_write = 1; wb_wreg = 5'd0;
    ex_rs = 5'd0; ex_rt = 5'd0;
    #1;
    vec_cnt++;
    if (pc_write !== 1'b1 || id_ex_flush !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      err_cnt++;
      $display("[TB] FAIL zero_reg: pc=%b idex_f=%b fwd_a=%b fwd_b=%b, required 1 0 00 00",
               pc_write, id_ex_flush, fwd_a, fwd_b);
    end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    mem_reg_write = 1; mem_wreg = 5'd5; wb_reg_write = 1; wb_wreg = 5'd5;
    ex_rs = 5'd5; ex_rt = 5'd7;
    #1;
    vec_cnt++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      err_cnt++;
      $display("[TB] FAIL fwd_mem_priority: fwd_a=%b fwd_b=%b, required 10 00", fwd_a, fwd_b);
    end
    mem_reg_write = 0; ex_rt = 5'd5;
    #1;
    vec_cnt++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      err_cnt++;
      $display("[TB] FAIL fwd_wb: fwd_a=%b fwd_b=%b, required 01 01", fwd_a, fwd_b);
    end
    mem_reg_write = 1; mem_wreg = 5'd7; ex_rs = 5'd7; ex_rt = 5'd5;
    #1;
    vec_cnt++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin
      err_cnt++;
      $display("[TB] FAIL fwd_split: fwd_a=%b fwd_b=%b, required 10 01", fwd_a, fwd_b);
    end
    wb_reg_write = 0;
    #1;
    vec_cnt++;
    if (fwd_b !== 2'b00) begin
      err_cnt++;
      $display("[TB] FAIL fwd_wb_off: fwd_b=%b, required 00", fwd_b);
    end
    clear_inputs();
  endtask

  task automatic test_redirect();
    do_reset();
    @(negedge clk);
    pcsrc_mem = 1;
    set_load_use();
    #1;
    vec_cnt++;
    if (pc_write !== 1'b1 || if_id_write !== 1'b1 || if_id_flush !== 1'b1 ||
        id_ex_flush !== 1'b1 || ex_mem_flush !== 1'b1 || pipe_hold !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL redirect: pc=%b ifid_w=%b flushes=%b%b%b hold=%b, required 1 1 111 0",
               pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold);
    end
    @(negedge clk);
    pcsrc_mem = 0;
    #1;
    vec_cnt++;
    if (pc_write !== 1'b1 || id_ex_flush !== 1'b0 || if_id_flush !== 1'b0 ||
        flush_cnt !== 1 || stall_cnt !== 0) begin
      err_cnt++;
      $display("[TB] FAIL redir_suppress: pc=%b idex_f=%b ifid_f=%b flush=%0d stall=%0d, required 1 0 0 1 0",
               pc_write, id_ex_flush, if_id_flush, flush_cnt, stall_cnt);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if (pc_write !== 1'b0 || id_ex_flush !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL redir_back_to_run: pc=%b idex_f=%b, required 0 1", pc_write, id_ex_flush);
    end
    @(negedge clk);
    clear_inputs();
    jump_mem = 1;
    #1;
    vec_cnt++;
    if (ex_mem_flush !== 1'b1 || if_id_flush !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL jump: ex_mem_flush=%b if_id_flush=%b, required 1 1", ex_mem_flush, if_id_flush);
    end
    @(negedge clk);
    jump_mem = 0;
    #1;
    vec_cnt++;
    if (flush_cnt !== 2 || stall_cnt !== 1) begin
      err_cnt++;
      $display("[TB] FAIL redirect_counts: flush=%0d stall=%0d, required 2 1", flush_cnt, stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_busy_redirect();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      dmem_busy = 1; pcsrc_mem = 1;
      #1;
      vec_cnt++;
      if (pipe_hold !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0 ||
          if_id_flush !== 1'b0 || id_ex_flush !== 1'b0 || ex_mem_flush !== 1'b0) begin
        err_cnt++;
        $display("[TB] FAIL busy_freeze cyc%0d: hold=%b pc=%b ifid_w=%b flushes=%b%b%b, required 1 0 0 000",
                 i, pipe_hold, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush);
      end
    end
    @(negedge clk);
    dmem_busy = 0; pcsrc_mem = 0;
    #1;
    vec_cnt++;
    if (pc_write !== 1'b1 || pipe_hold !== 1'b0 || if_id_flush !== 1'b1 ||
        id_ex_flush !== 1'b1 || ex_mem_flush !== 1'b1 || stall_cnt !== 3) begin
      err_cnt++;
      $display("[TB] FAIL busy_pending_redirect: pc=%b hold=%b flushes=%b%b%b stall=%0d, required 1 0 111 3",
               pc_write, pipe_hold, if_id_flush, id_ex_flush, ex_mem_flush, stall_cnt);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if (if_id_flush !== 1'b0 || ex_mem_flush !== 1'b0 || flush_cnt !== 1) begin
      err_cnt++;
      $display("[TB] FAIL pending_cleared: ifid_f=%b exmem_f=%b flush=%0d, required 0 0 1",
               if_id_flush, ex_mem_flush, flush_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      dmem_busy = 1;
      #1;
      vec_cnt++;
      if (mem_timeout !== ((i >= 5) ? 1'b1 : 1'b0)) begin
        err_cnt++;
        $display("[TB] FAIL wdog cyc%0d: mem_timeout=%b, required %b", i, mem_timeout, (i >= 5));
      end
    end
    @(negedge clk);
    dmem_busy = 0;
    #1;
    vec_cnt++;
    if (mem_timeout !== 1'b1 || pc_write !== 1'b1 || stall_cnt !== 10) begin
      err_cnt++;
      $display("[TB] FAIL wdog_sticky: timeout=%b pc=%b stall=%0d, required 1 1 10",
               mem_timeout, pc_write, stall_cnt);
    end
  endtask

  task automatic test_counter_saturation();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dmem_busy = 1;
    end
    @(negedge clk);
    dmem_busy = 0;
    #1;
    vec_cnt++;
    if (stall_cnt !== 4'hF) begin
      err_cnt++;
      $display("[TB] FAIL stall_saturate: stall=%0d, required 15", stall_cnt);
    end
    do_reset();
    #1;
    vec_cnt++;
    if (mem_timeout !== 1'b0 || stall_cnt !== 0) begin
      err_cnt++;
      $display("[TB] FAIL wdog_reset_clear: timeout=%b stall=%0d, required 0 0", mem_timeout, stall_cnt);
    end
  endtask

  task automatic test_watchdog_clear();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dmem_busy = (i != 3);
    end
    @(negedge clk);
    dmem_busy = 0;
    #1;
    vec_cnt++;
    if (mem_timeout !== 1'b0 || stall_cnt !== 6) begin
      err_cnt++;
      $display("[TB] FAIL wdog_clears_on_idle: timeout=%b stall=%0d, required 0 6", mem_timeout, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_memw();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dmem_busy = 1; pcsrc_mem = 1;
    end
    @(negedge clk);
    reset = 1'b1; dmem_busy = 0; pcsrc_mem = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (if_id_flush !== 1'b0 || ex_mem_flush !== 1'b0 || pc_write !== 1'b1 || pipe_hold !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL reset_drops_pending: ifid_f=%b exmem_f=%b pc=%b hold=%b, required 0 0 1 0",
               if_id_flush, ex_mem_flush, pc_write, pipe_hold);
    end
    @(negedge clk);
    set_load_use();
    #1;
    vec_cnt++;
    if (pc_write !== 1'b0 || id_ex_flush !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL reset_to_run: pc=%b idex_f=%b, required 0 1", pc_write, id_ex_flush);
    end
    clear_inputs();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset   = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_forwarding();
    test_redirect();
    test_busy_redirect();
    test_watchdog();
    test_counter_saturation();
    test_watchdog_clear();
    test_reset_mid_memw();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
